// File: rtl/wb_ram_burst.sv
// wb_ram_burst
//   Wishbone B4 single-port RAM slave with:
//   - an inferred DEPTH x DW array (synchronous read, byte-enabled write)
//   - WAIT programmable wait states before the first ack of each cycle
//   - a one-cycle err response for word indices >= DEPTH
//   - optional registered-feedback bursts (CTI 010 / 111, BTE linear or wrap-4/8/16),
//     compiled in only when the macro WB_RAM_BURST_EN is defined. Without it, CTI and
//     BTE are ignored and every access is classic.
//   All outputs are registered.
//
// Ports
//   wb_clk_i  in   clock, rising edge
//   wb_rst_i  in   asynchronous active-high reset
//   wb_adr_i  in   byte address; word index = wb_adr_i >> log2(DW/8)
//   wb_dat_i  in   write data
//   wb_dat_o  out  read data (valid while wb_ack_o=1)
//   wb_sel_i  in   byte enables for writes
//   wb_we_i   in   write enable
//   wb_cyc_i  in   bus cycle
//   wb_stb_i  in   strobe
//   wb_cti_i  in   cycle type (000 classic, 010 incr burst, 111 end of burst)
//   wb_bte_i  in   burst type (00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16)
//   wb_ack_o  out  acknowledge
//   wb_err_o  out  error (out-of-range word index)
//
// Parameters: AW byte address width, DW data width (32 or 64), DEPTH words
// (power of two, >= 16 for wrap-16), WAIT first-beat wait states (0..15).
module wb_ram_burst #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int WAIT  = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int SW  = DW / 8;
  localparam int BSH = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);
  localparam int XW  = AW - BSH;

  // XFER is the response cycle: ack (or err) is high while in it.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
`ifdef WB_RAM_BURST_EN
  localparam logic [1:0] S_BURST = 2'd3;
`endif

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] addr_q, addr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q;
  logic          rd_en;
  logic [IW-1:0] rd_addr;

  logic          req;
  logic [XW-1:0] widx;
  logic          in_range;
  logic          mem_we;

  assign req      = wb_cyc_i & wb_stb_i;
  assign widx     = wb_adr_i[AW-1:BSH];
  assign in_range = (widx >> IW) == '0;

  // ack_q is only ever high in XFER/BURST, so it marks the edge that ends a beat.
  assign mem_we = ack_q & req & wb_we_i;

`ifdef WB_RAM_BURST_EN
  logic [IW:0]   lin_nxt;
  logic [IW-1:0] wmask;
  logic [IW-1:0] bnxt;
  logic          bovf;
  logic          burst_go;
  logic          unused_ok;

  assign unused_ok = ^wb_adr_i[BSH-1:0];
  assign lin_nxt   = {1'b0, addr_q} + (IW+1)'(1);

  always_comb begin
    wmask = '0;
    case (wb_bte_i)
      2'b01:   wmask = IW'(3);
      2'b10:   wmask = IW'(7);
      2'b11:   wmask = IW'(15);
      default: wmask = '0;
    endcase
  end

  // Wrap bursts only roll the low bits; linear bursts carry into the top bit,
  // which flags a run off the end of the array.
  always_comb begin
    if (wb_bte_i == 2'b00) begin
      bnxt = lin_nxt[IW-1:0];
      bovf = lin_nxt[IW];
    end else begin
      bnxt = (addr_q & ~wmask) | (lin_nxt[IW-1:0] & wmask);
      bovf = 1'b0;
    end
  end

  assign burst_go = ack_q & req & (wb_cti_i == 3'b010);
`else
  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[BSH-1:0], wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!in_range) begin
            // err uses the response cycle too, so the still-high stb is not resampled.
            err_d   = 1'b1;
            state_d = S_XFER;
          end else begin
            addr_d = widx[IW-1:0];
            if (WAIT == 0) begin
              ack_d   = 1'b1;
              rd_en   = 1'b1;
              rd_addr = widx[IW-1:0];
              state_d = S_XFER;
            end else begin
              cnt_d   = 4'(WAIT - 1);
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          ack_d   = 1'b1;
          rd_en   = 1'b1;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef WB_RAM_BURST_EN
      S_XFER, S_BURST: begin
        state_d = S_IDLE;
        if (burst_go) begin
          if (bovf) begin
            err_d   = 1'b1;
            state_d = S_XFER;
          end else begin
            // Prefetch the next beat so data is on the bus with the next ack.
            addr_d  = bnxt;
            ack_d   = 1'b1;
            rd_en   = 1'b1;
            rd_addr = bnxt;
            state_d = S_BURST;
          end
        end
      end
`else
      S_XFER: begin
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (rd_en) dat_q <= mem[rd_addr];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < SW; i++) begin
        if (wb_sel_i[i]) mem[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
